// File: rtl/spi_ahb_loader_if.sv
// AHB-Lite bus bundle between the SPI loader (master) and the slave/router.
// Address-phase controls, write data and the slave response travel together.
interface spi_ahb_loader_if;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        hready;
    logic        hresp;

    modport master (
        output haddr, hwrite, hsize, hburst, hprot, hmastlock, htrans, hwdata,
        input  hready, hresp
    );

    modport slave (
        input  haddr, hwrite, hsize, hburst, hprot, hmastlock, htrans, hwdata,
        output hready, hresp
    );
endinterface

// File: rtl/spi_ahb_loader.sv
// SPI (mode 0) boot loader: decodes A5/5A command frames from an external host and
// writes the received 32-bit words to AHB, then hands the bus over via load_done.
module spi_ahb_loader #(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_sclk,
    input  logic             spi_mosi,
    input  logic             spi_cs_n,
    spi_ahb_loader_if.master ahb,
    output logic             load_done,
    output logic             overrun,
    output logic             bus_err
);

    typedef enum logic [2:0] {
        CMD, ADDR_HI, ADDR_LO, DATA, SKIP, DONE_WAIT
    } frame_state_t;

    typedef enum logic [1:0] {
        A_IDLE, A_ADDR, A_DATA
    } ahb_state_t;

    localparam logic [7:0] CMD_LOAD = 8'hA5;
    localparam logic [7:0] CMD_DONE = 8'h5A;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_n_sync;
    logic                   r_sclk_prev;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic [1:0]             r_byte_idx;
    logic [23:0]            r_word_acc;
    logic [15:0]            r_ptr;
    logic                   r_buf_valid;
    logic [31:0]            r_buf_data;
    logic [31:0]            r_haddr;
    logic [31:0]            r_hwdata;
    logic                   r_load_done;
    logic                   r_overrun;
    logic                   r_bus_err;
    frame_state_t           r_frame_state;
    frame_state_t           w_frame_next;
    ahb_state_t             r_ahb_state;
    ahb_state_t             w_ahb_next;

    logic        w_sclk;
    logic        w_mosi;
    logic        w_cs_n;
    logic        w_bit_en;
    logic        w_byte_done;
    logic [7:0]  w_byte;
    logic [31:0] w_word;
    logic        w_word_done;
    logic        w_ahb_done;
    logic        w_drop;
    logic [15:0] w_ptr_step;

    // ---------------------------------------------------------------- SPI front end
    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_n = r_cs_n_sync[SYNC_STAGES-1];

    // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_n_sync <= '1;
            r_sclk_prev <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_cs_n_sync <= {r_cs_n_sync[SYNC_STAGES-2:0], spi_cs_n};
            r_sclk_prev <= w_sclk;
        end
    end

    assign w_bit_en    = w_sclk & ~r_sclk_prev & ~w_cs_n;
    assign w_byte_done = w_bit_en && (r_bit_cnt == 3'd7);
    assign w_byte      = {r_shift[6:0], w_mosi};
    assign w_word      = {r_word_acc, w_byte};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
        end else if (w_cs_n) begin
            r_bit_cnt <= 3'd0;
        end else if (w_bit_en) begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 3'd1;
        end
    end

    // ---------------------------------------------------------------- frame FSM
    always_ff @(posedge clk) begin
        if (reset) r_frame_state <= CMD;
        else       r_frame_state <= w_frame_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_frame_next = r_frame_state;
        w_word_done  = 1'b0;
        if (w_cs_n && r_frame_state != DONE_WAIT) begin
            w_frame_next = CMD;
        end else if (w_byte_done) begin
            case (r_frame_state)
                CMD: begin
                    if (w_byte == CMD_LOAD)      w_frame_next = ADDR_HI;
                    else if (w_byte == CMD_DONE) w_frame_next = DONE_WAIT;
                    else                         w_frame_next = SKIP;
                end
                ADDR_HI: w_frame_next = ADDR_LO;
                ADDR_LO: w_frame_next = DATA;
                DATA:    w_word_done  = (r_byte_idx == 2'd3);
                default: w_frame_next = r_frame_state;
            endcase
        end
    end

    // A dropped word still consumes its address slot, so ptr can advance twice in one cycle.
    assign w_ahb_done = (r_ahb_state == A_DATA) && ahb.hready;
    assign w_drop     = w_word_done && r_buf_valid && !w_ahb_done;
    assign w_ptr_step = {13'd0, w_ahb_done & w_drop, w_ahb_done ^ w_drop, 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte_idx  <= 2'd0;
            r_ptr       <= 16'd0;
            r_buf_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_cs_n)
                r_byte_idx <= 2'd0;
            else if (w_byte_done && r_frame_state == DATA)
                r_byte_idx <= r_byte_idx + 2'd1;

            if (w_byte_done && r_frame_state == ADDR_HI)
                r_ptr[15:8] <= w_byte;
            else if (w_byte_done && r_frame_state == ADDR_LO)
                r_ptr[7:0] <= w_byte;
            else
                r_ptr <= r_ptr + w_ptr_step;

            if (w_word_done && (!r_buf_valid || w_ahb_done))
                r_buf_valid <= 1'b1;
            else if (w_ahb_done)
                r_buf_valid <= 1'b0;

            if (w_drop)
                r_overrun <= 1'b1;
        end
    end

    // NOTE: data-only storage is left unreset; r_buf_valid and r_byte_idx say when it is meaningful.
    always_ff @(posedge clk) begin
        if (w_byte_done && r_frame_state == DATA)
            r_word_acc <= {r_word_acc[15:0], w_byte};
        if (w_word_done && (!r_buf_valid || w_ahb_done))
            r_buf_data <= w_word;
    end

    // ---------------------------------------------------------------- AHB master FSM
    always_ff @(posedge clk) begin
        if (reset) r_ahb_state <= A_IDLE;
        else       r_ahb_state <= w_ahb_next;
    end

    always_comb begin
        w_ahb_next = r_ahb_state;
        case (r_ahb_state)
            A_IDLE:  if (r_buf_valid) w_ahb_next = A_ADDR;
            A_ADDR:  w_ahb_next = A_DATA;
            A_DATA:  if (ahb.hready) w_ahb_next = A_IDLE;
            default: w_ahb_next = A_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_haddr     <= 32'd0;
            r_hwdata    <= 32'd0;
            r_load_done <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            if (r_ahb_state == A_IDLE && r_buf_valid)
                r_haddr <= {16'h0000, r_ptr};
            if (r_ahb_state == A_ADDR)
                r_hwdata <= r_buf_data;
            if (w_ahb_done && ahb.hresp)
                r_bus_err <= 1'b1;
            if (r_frame_state == DONE_WAIT && !r_buf_valid && r_ahb_state == A_IDLE)
                r_load_done <= 1'b1;
        end
    end

    always_comb begin
        ahb.htrans = 2'b00;
        ahb.hwrite = 1'b0;
        if (r_ahb_state == A_ADDR) begin
            ahb.htrans = 2'b10;
            ahb.hwrite = 1'b1;
        end
    end

    assign ahb.haddr     = r_haddr;
    assign ahb.hwdata    = r_hwdata;
    assign ahb.hsize     = 3'b010;
    assign ahb.hburst    = 3'b000;
    assign ahb.hprot     = 4'b0011;
    assign ahb.hmastlock = 1'b0;

    assign load_done = r_load_done;
    assign overrun   = r_overrun;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_spi_ahb_loader.sv
// Directed bench for spi_ahb_loader: SPI frames in, AHB writes captured by a bus monitor
// and compared against hand-computed addresses and data.
module tb_spi_ahb_loader;

    logic clk = 1'b0;
    logic reset;
    logic spi_sclk;
    logic spi_mosi;
    logic spi_cs_n;
    logic load_done;
    logic overrun;
    logic bus_err;

    spi_ahb_loader_if bus ();

    spi_ahb_loader #(
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_cs_n  (spi_cs_n),
        .ahb       (bus),
        .load_done (load_done),
        .overrun   (overrun),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic [11:0] got_ctrl[$];
    bit          mon_pending;
    bit          mon_first;
    logic [31:0] mon_hold;
    int          stall_cycles;
    int          unstable;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Bus monitor: samples 1 ns after the falling edge, i.e. after the bench drives inputs.
    always begin
        @(negedge clk);
        #1;
        if (reset) begin
            mon_pending = 1'b0;
        end else begin
            if (mon_pending) begin
                if (mon_first) begin
                    mon_hold  = bus.hwdata;
                    mon_first = 1'b0;
                end
                if (bus.hready) begin
                    got_data.push_back(bus.hwdata);
                    mon_pending = 1'b0;
                end else begin
                    stall_cycles++;
                    if (bus.hwdata !== mon_hold) unstable++;
                end
            end
            if (bus.htrans == 2'b10) begin
                got_addr.push_back(bus.haddr);
                got_ctrl.push_back({bus.hwrite, bus.hsize, bus.hburst, bus.hprot, bus.hmastlock});
                mon_pending = 1'b1;
                mon_first   = 1'b1;
            end
        end
    end

    function automatic logic [31:0] addr_at(input int i);
        return (i < got_addr.size()) ? got_addr[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] data_at(input int i);
        return (i < got_data.size()) ? got_data[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset      = 1'b1;
        spi_sclk   = 1'b0;
        spi_mosi   = 1'b0;
        spi_cs_n   = 1'b1;
        bus.hready = 1'b1;
        bus.hresp  = 1'b0;
        cyc(2);
        reset = 1'b0;
        got_addr.delete();
        got_data.delete();
        got_ctrl.delete();
        stall_cycles = 0;
        unstable     = 0;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = b[i];
            cyc(4);
            spi_sclk = 1'b1;
            cyc(4);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        spi_byte(w[31:24]);
        spi_byte(w[23:16]);
        spi_byte(w[15:8]);
        spi_byte(w[7:0]);
    endtask

    task automatic frame_begin();
        spi_cs_n = 1'b0;
        cyc(4);
    endtask

    task automatic frame_end();
        cyc(4);
        spi_cs_n = 1'b1;
        cyc(8);
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int i = 0; i < budget && got_data.size() < n; i++) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        apply_reset();

        // Reset values of every output
        cyc(1);
        check("rst_htrans", {30'd0, bus.htrans}, 32'd0);
        check("rst_haddr", bus.haddr, 32'd0);
        check("rst_hwdata", bus.hwdata, 32'd0);
        check("rst_hwrite", {31'd0, bus.hwrite}, 32'd0);
        check("rst_hsize", {29'd0, bus.hsize}, 32'd2);
        check("rst_hburst", {29'd0, bus.hburst}, 32'd0);
        check("rst_hprot", {28'd0, bus.hprot}, 32'd3);
        check("rst_hmastlock", {31'd0, bus.hmastlock}, 32'd0);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);

        // Single word, zero-wait slave
        frame_begin();
        spi_byte(8'hA5); spi_byte(8'h00); spi_byte(8'h10);
        send_word(32'hDEADBEEF);
        frame_end();
        wait_writes(1, 100);
        cyc(20);
        check("t1_count", got_addr.size(), 32'd1);
        check("t1_addr", addr_at(0), 32'h0000_0010);
        check("t1_data", data_at(0), 32'hDEAD_BEEF);
        check("t1_ctrl", (got_ctrl.size() > 0) ? {20'd0, got_ctrl[0]} : 32'hFFFF_FFFF, 32'h0000_0A06);

        // Three consecutive words, pointer increments by 4
        apply_reset();
        frame_begin();
        spi_byte(8'hA5); spi_byte(8'h40); spi_byte(8'h00);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        send_word(32'h3333_3333);
        frame_end();
        wait_writes(3, 100);
        check("t2_count", got_data.size(), 32'd3);
        check("t2_addr0", addr_at(0), 32'h0000_4000);
        check("t2_addr1", addr_at(1), 32'h0000_4004);
        check("t2_addr2", addr_at(2), 32'h0000_4008);
        check("t2_data0", data_at(0), 32'h1111_1111);
        check("t2_data1", data_at(1), 32'h2222_2222);
        check("t2_data2", data_at(2), 32'h3333_3333);
        check("t2_overrun", {31'd0, overrun}, 32'd0);

        // Long wait state: second word dropped, third word lands at base+8
        apply_reset();
        bus.hready = 1'b0;
        frame_begin();
        spi_byte(8'hA5); spi_byte(8'h01); spi_byte(8'h00);
        send_word(32'hA1A1_A1A1);
        cyc(8);
        send_word(32'hB2B2_B2B2);
        cyc(8);
        bus.hready = 1'b1;
        send_word(32'hC3C3_C3C3);
        frame_end();
        wait_writes(2, 200);
        check("t3_count", got_data.size(), 32'd2);
        check("t3_addr0", addr_at(0), 32'h0000_0100);
        check("t3_data0", data_at(0), 32'hA1A1_A1A1);
        check("t3_addr1", addr_at(1), 32'h0000_0108);
        check("t3_data1", data_at(1), 32'hC3C3_C3C3);
        check("t3_overrun", {31'd0, overrun}, 32'd1);
        check("t3_hwdata_stable", unstable, 32'd0);
        check("t3_stall_ge_200", {31'd0, stall_cycles >= 200}, 32'd1);

        // Partial word abandoned by cs_n, then a fresh frame to address 0
        apply_reset();
        frame_begin();
        spi_byte(8'hA5); spi_byte(8'h00); spi_byte(8'h80);
        spi_byte(8'h11); spi_byte(8'h22);
        frame_end();
        frame_begin();
        spi_byte(8'hA5); spi_byte(8'h00); spi_byte(8'h00);
        send_word(32'h5566_7788);
        frame_end();
        wait_writes(1, 100);
        cyc(20);
        check("t4_count", got_addr.size(), 32'd1);
        check("t4_addr", addr_at(0), 32'h0000_0000);
        check("t4_data", data_at(0), 32'h5566_7788);

        // Done command while a write is pending; error response on that write
        apply_reset();
        bus.hready = 1'b0;
        frame_begin();
        spi_byte(8'hA5); spi_byte(8'h00); spi_byte(8'h20);
        send_word(32'h0BAD_F00D);
        frame_end();
        frame_begin();
        spi_byte(8'h5A);
        frame_end();
        cyc(20);
        check("t5_done_held_off", {31'd0, load_done}, 32'd0);
        bus.hready = 1'b1;
        bus.hresp  = 1'b1;
        cyc(1);
        bus.hresp = 1'b0;
        for (int i = 0; i < 50 && !load_done; i++) @(negedge clk);
        check("t5_load_done", {31'd0, load_done}, 32'd1);
        check("t5_bus_err", {31'd0, bus_err}, 32'd1);
        check("t5_addr", addr_at(0), 32'h0000_0020);
        check("t5_data", data_at(0), 32'h0BAD_F00D);
        frame_begin();
        spi_byte(8'hA5); spi_byte(8'h00); spi_byte(8'h30);
        send_word(32'h1234_5678);
        frame_end();
        cyc(20);
        check("t5_ignored_count", got_addr.size(), 32'd1);
        check("t5_done_sticky", {31'd0, load_done}, 32'd1);

        // Unknown command skipped, next frame decoded normally
        apply_reset();
        frame_begin();
        spi_byte(8'h33); spi_byte(8'hDE); spi_byte(8'hAD); spi_byte(8'hBE); spi_byte(8'hEF);
        frame_end();
        frame_begin();
        spi_byte(8'hA5); spi_byte(8'h00); spi_byte(8'h40);
        send_word(32'h0102_0304);
        frame_end();
        wait_writes(1, 100);
        cyc(20);
        check("t6_count", got_addr.size(), 32'd1);
        check("t6_addr", addr_at(0), 32'h0000_0040);
        check("t6_data", data_at(0), 32'h0102_0304);

        // Reset during the data phase abandons the write
        bus.hready = 1'b0;
        frame_begin();
        spi_byte(8'hA5); spi_byte(8'h00); spi_byte(8'h50);
        send_word(32'h89AB_CDEF);
        for (int i = 0; i < 100 && got_addr.size() < 2; i++) @(negedge clk);
        check("t6_second_nonseq", got_addr.size(), 32'd2);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("t6_rst_htrans", {30'd0, bus.htrans}, 32'd0);
        check("t6_rst_load_done", {31'd0, load_done}, 32'd0);
        check("t6_rst_hwdata", bus.hwdata, 32'd0);
        bus.hready = 1'b1;
        frame_end();
        cyc(20);
        check("t6_no_resume", got_addr.size(), 32'd2);
        check("t6_no_data", got_data.size(), 32'd1);
        check("t6_idle_htrans", {30'd0, bus.htrans}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_ahb_loader.md
SPI_AHB_LOADER -- requirements
Module: spi_ahb_loader

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, setting the synchronizer depth for spi_sclk, spi_mosi and spi_cs_n; legal range 2-3.
REQ-002 SHALL have clk, input, 1: system clock; all logic on its rising edge.
REQ-003 SHALL have reset, input, 1: synchronous, active-high reset; clock is clk.
REQ-004 SHALL have spi_sclk, input, 1: SPI clock, mode 0, asynchronous to clk, at most clk/8.
REQ-005 SHALL have spi_mosi, input, 1: serial data, MSB first, sampled on spi_sclk rise.
REQ-006 SHALL have spi_cs_n, input, 1: active-low frame select.
REQ-007 SHALL have haddr, output, 32: AHB address.
REQ-008 SHALL have hwrite, output, 1; hsize, output, 3; hburst, output, 3; hprot, output, 4; hmastlock, output, 1: AHB control.
REQ-009 SHALL have htrans, output, 2: AHB transfer type; hwdata, output, 32: AHB write data.
REQ-010 SHALL have hready, input, 1, and hresp, input, 1: AHB slave response.
REQ-011 SHALL have load_done, output, 1: level that hands the bus to the core; drives the router's SPI_change.
REQ-012 SHALL have overrun, output, 1, sticky: a data word was dropped.
REQ-013 SHALL have bus_err, output, 1, sticky: hresp=1 was seen in a data phase.

Function
REQ-014 SHALL pass spi_sclk, spi_mosi and spi_cs_n through SYNC_STAGES flops, then detect the sclk rising edge with one extra flop; a bit is captured on each detected edge while synchronized cs_n=0.
REQ-015 SHALL shift bits MSB first into an 8-bit register; a 3-bit counter marks a byte complete on its 8th bit and wraps 7->0.
REQ-016 SHALL implement a frame FSM with states CMD, ADDR_HI, ADDR_LO, DATA, SKIP, DONE_WAIT; reset state is CMD.
REQ-017 CMD: byte 0xA5 -> ADDR_HI; byte 0x5A -> DONE_WAIT; any other byte -> SKIP.
REQ-018 ADDR_HI/ADDR_LO: load addr[15:8] and then addr[7:0] of a 16-bit word pointer; ADDR_LO -> DATA.
REQ-019 DATA: assemble 4 bytes big-endian into one 32-bit word; on the 4th byte, the word goes to the 1-entry buffer and the byte index returns to 0.
REQ-020 SKIP: ignore all bytes until the frame ends.
REQ-021 Synchronized cs_n=1 SHALL clear the bit counter and byte index, discard any partial word, and return the FSM to CMD, except in DONE_WAIT; a buffered word is kept.
REQ-022 If a word completes while the buffer is full, that word SHALL be dropped, overrun set to 1, and the pointer still advanced by 4.
REQ-023 The AHB FSM SHALL have states A_IDLE, A_ADDR, A_DATA.
REQ-024 A_IDLE with the buffer full: go to A_ADDR on the next edge, so htrans=2'b10 exactly one cycle after the word completes.
REQ-025 A_ADDR outputs, held for one cycle: htrans=2'b10, haddr={16'h0, ptr}, hwrite=1, hsize=3'b010, hburst=3'b000, hprot=4'b0011, hmastlock=0; the next state is A_DATA.
REQ-026 A_DATA: htrans=2'b00; hwdata=buffer, held until hready=1.
REQ-027 A_DATA with hready=1: free the buffer, increment ptr by 4 (16-bit wrap, 0xFFFC->0x0000), and return to A_IDLE.
REQ-028 A_DATA with hready=1 and hresp=1: set bus_err=1; there is no retry.
REQ-029 When idle, the AHB outputs SHALL be htrans=2'b00, hwrite=0 and hwdata held.
REQ-030 DONE_WAIT: once the buffer is empty and the AHB FSM is in A_IDLE, set load_done=1.
REQ-031 load_done SHALL stay 1 until reset; DONE_WAIT ignores all further SPI activity.
REQ-032 If a word completes and hready=1 finishes in the same cycle, the buffer SHALL hold the new word with no overrun.

Reset
REQ-033 On reset=1 at a clk edge, all state SHALL clear: frame FSM=CMD, AHB FSM=A_IDLE, ptr=0, buffer empty.
REQ-034 Output reset values: htrans=0, haddr=0, hwdata=0, hwrite=0, hsize=3'b010, hburst=0, hprot=4'b0011, hmastlock=0, load_done=0, overrun=0, bus_err=0.
REQ-035 Reset in the middle of a transfer SHALL abandon it, with htrans=0 on the cycle after reset.

Verification
REQ-036 Frame A5 00 10 DE AD BE EF, hready=1 -> one NONSEQ, haddr=0x00000010, then hwdata=0xDEADBEEF in the next cycle.
REQ-037 Frame A5 40 00 followed by 3 words -> haddr sequence 0x4000, 0x4004, 0x4008 with the data in order; no overrun.
REQ-038 hready held 0 for 200 cycles during a data phase while two more words arrive -> hwdata stable, one word dropped, overrun=1.
REQ-039 cs_n raised after 2 data bytes, then A5 00 00 plus one word -> the partial word is never written; a single write goes to 0x0000.
REQ-040 Frame 5A sent while a write is pending -> load_done rises only after hready completes that write and stays 1; a following frame has no effect.
REQ-041 Command byte 0x33, then a new frame A5 -> the 0x33 frame is skipped and the new frame is decoded normally; reset during A_DATA -> htrans=0 and load_done=0.
